// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// mem_port_arbiter
// Shares one single-ported unified memory between an instruction-fetch port
// (if_*) and a data port (dm_*). One access is in flight at a time.
//
// Handshake (both requester ports): a requester raises *_req_i with its
// address/data and holds everything stable until it sees *_ack_o high for
// one cycle; *_rdata_o is valid in that ack cycle and holds afterwards.
// The memory side sees mem_req_o held high until it answers with a one-cycle
// mem_ack_i carrying mem_rdata_i.
//
// Ports
//   clk, reset                 clock, asynchronous active-low reset
//   if_req_i/if_addr_i         fetch request and address
//   if_rdata_o/if_ack_o        fetch read data and one-cycle completion
//   dm_req_i/dm_we_i/dm_addr_i/dm_wdata_i/dm_strb_i   data request
//   dm_rdata_o/dm_ack_o        data read data and one-cycle completion
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_strb_o  memory request
//   mem_rdata_i/mem_ack_i      memory response
//   stall_fetch_o/stall_mem_o  requester is waiting on this arbiter
//   err_o                      pulses with the ack of an access that timed out
module mem_port_arbiter #(
   parameter int MAX_DM_RUN = 3,
   parameter int TIMEOUT    = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic [31:0] if_rdata_o,
   output logic        if_ack_o,
   input  logic        dm_req_i,
   input  logic        dm_we_i,
   input  logic [31:0] dm_addr_i,
   input  logic [31:0] dm_wdata_i,
   input  logic [3:0]  dm_strb_i,
   output logic [31:0] dm_rdata_o,
   output logic        dm_ack_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic [3:0]  mem_strb_o,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_ack_i,
   output logic        stall_fetch_o,
   output logic        stall_mem_o,
   output logic        err_o
);

   localparam int RUN_W = (MAX_DM_RUN < 1) ? 1 : $clog2(MAX_DM_RUN + 1);
   localparam int WD_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DM_RUN);
   // The watchdog expires when this BUSY cycle would bring it to TIMEOUT.
   localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY, RESP} state_t;

   state_t           state;
   state_t           state_nxt;
   logic             owner_dm;   // 1: data port owns the current access
   logic             timed_out;  // current access ended by the watchdog
   logic [RUN_W-1:0] dm_run;
   logic [WD_W-1:0]  wdog;
   logic [31:0]      addr_q;
   logic [31:0]      wdata_q;
   logic             we_q;
   logic [3:0]       strb_q;
   logic [31:0]      if_rdata_q;
   logic [31:0]      dm_rdata_q;

   logic             busy;
   logic             grant_if;
   logic             grant_dm;
   logic             wd_expire;

   assign busy = (state == IF_BUSY) || (state == DM_BUSY);

   always_comb begin
      state_nxt = state;
      grant_if  = 1'b0;
      grant_dm  = 1'b0;
      wd_expire = 1'b0;
      case (state)
         IDLE: begin
            // The data port wins ties until it has taken MAX_DM_RUN grants in a
            // row over a waiting fetch; then the fetch gets one turn.
            if (dm_req_i && !(if_req_i && (dm_run == RUN_MAX))) begin
               grant_dm  = 1'b1;
               state_nxt = DM_BUSY;
            end else if (if_req_i) begin
               grant_if  = 1'b1;
               state_nxt = IF_BUSY;
            end
         end
         IF_BUSY, DM_BUSY: begin
            if (mem_ack_i) begin
               state_nxt = RESP;
            end else if (wdog == WD_LAST) begin
               wd_expire = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         owner_dm   <= 1'b0;
         timed_out  <= 1'b0;
         dm_run     <= '0;
         wdog       <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         strb_q     <= 4'h0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         state <= state_nxt;
         if (grant_dm) begin
            owner_dm  <= 1'b1;
            timed_out <= 1'b0;
            wdog      <= '0;
            addr_q    <= dm_addr_i;
            wdata_q   <= dm_wdata_i;
            we_q      <= dm_we_i;
            strb_q    <= dm_strb_i;
            if (if_req_i && (dm_run != RUN_MAX)) begin
               dm_run <= dm_run + RUN_W'(1);
            end
         end else if (grant_if) begin
            owner_dm  <= 1'b0;
            timed_out <= 1'b0;
            wdog      <= '0;
            addr_q    <= if_addr_i;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            strb_q    <= 4'h0;
            dm_run    <= '0;
         end else if (busy) begin
            if (mem_ack_i) begin
               if (owner_dm) begin
                  dm_rdata_q <= mem_rdata_i;
               end else begin
                  if_rdata_q <= mem_rdata_i;
               end
            end else begin
               wdog <= wdog + WD_W'(1);
               if (wd_expire) begin
                  timed_out <= 1'b1;
               end
            end
         end
      end
   end

   assign mem_req_o     = busy;
   assign mem_we_o      = we_q;
   assign mem_addr_o    = addr_q;
   assign mem_wdata_o   = wdata_q;
   assign mem_strb_o    = strb_q;
   assign if_rdata_o    = if_rdata_q;
   assign dm_rdata_o    = dm_rdata_q;
   assign if_ack_o      = (state == RESP) && !owner_dm;
   assign dm_ack_o      = (state == RESP) && owner_dm;
   assign err_o         = (state == RESP) && timed_out;
   assign stall_fetch_o = if_req_i & ~if_ack_o;
   assign stall_mem_o   = dm_req_i & ~dm_ack_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// Bench for mem_port_arbiter: requester driver tasks, a memory responder that
// also predicts each grant from the arbitration rules, and a monitor that
// pops expected responses whenever a requester is acked.
module tb_mem_port_arbiter;

   localparam int MAX_DM_RUN = 3;
   localparam int TIMEOUT    = 255;
   localparam int WAIT_BOUND = 1500;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT ----------------
   logic        if_req_i, if_ack_o, dm_req_i, dm_we_i, dm_ack_o;
   logic [31:0] if_addr_i, if_rdata_o, dm_addr_i, dm_wdata_i, dm_rdata_o;
   logic [3:0]  dm_strb_i, mem_strb_o;
   logic        mem_req_o, mem_we_o, mem_ack_i;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
   logic        stall_fetch_o, stall_mem_o, err_o;

   mem_port_arbiter #(.MAX_DM_RUN(MAX_DM_RUN), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
      .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
      .dm_strb_i(dm_strb_i), .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_strb_o(mem_strb_o), .mem_rdata_i(mem_rdata_i),
      .mem_ack_i(mem_ack_i), .stall_fetch_o(stall_fetch_o), .stall_mem_o(stall_mem_o),
      .err_o(err_o)
   );

   // ---------------- scoreboard state ----------------
   int          checks = 0;
   int          errors = 0;
   logic [32:0] if_exp_q[$];   // {err, rdata}
   logic [32:0] dm_exp_q[$];
   logic [31:0] if_last = '0;  // rdata each side should currently hold
   logic [31:0] dm_last = '0;
   byte         grant_log[$];  // "D" / "I" per predicted grant
   int          model_run = 0;
   int          fixed_lat = -1; // >=0 forces the memory latency
   bit          force_spur = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Memory contents as a pure function of the address.
   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      if (a == 32'h100) return 32'h2402000A;
      return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
   endfunction

   // Addresses in the top 256 MB are never acknowledged by the memory.
   function automatic bit is_hang(input logic [31:0] a);
      return a[31:28] == 4'hF;
   endfunction

   // ---------------- driver tasks ----------------
   // All tasks start and end just after a rising edge.
   task automatic if_start(input logic [31:0] a);
      if_addr_i = a;
      if_req_i  = 1'b1;
      if (is_hang(a)) begin
         if_exp_q.push_back({1'b1, if_last});
      end else begin
         if_last = mem_fn(a);
         if_exp_q.push_back({1'b0, if_last});
      end
   endtask

   task automatic if_wait(input int unsigned c0, output int lat);
      bit got = 1'b0;
      for (int i = 0; i < WAIT_BOUND && !got; i++) begin
         @(negedge clk);
         if (if_ack_o) got = 1'b1;
      end
      lat = int'(cyc - c0);
      if (!got) chk("if_ack_wait", {63'd0, got}, 64'd1);
      @(posedge clk); #1;
      if_req_i = 1'b0;
   endtask

   task automatic if_issue(input logic [31:0] a, input int gap, output int lat);
      int unsigned c0;
      repeat (gap) begin @(posedge clk); #1; end
      if_start(a);
      c0 = cyc;
      if_wait(c0, lat);
   endtask

   task automatic dm_issue(input logic [31:0] a, input logic we, input logic [31:0] wd,
                           input logic [3:0] st, input int gap, output int lat);
      int unsigned c0;
      bit got = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      dm_addr_i = a; dm_we_i = we; dm_wdata_i = wd; dm_strb_i = st;
      dm_req_i  = 1'b1;
      if (is_hang(a)) begin
         dm_exp_q.push_back({1'b1, dm_last});
      end else begin
         dm_last = mem_fn(a);
         dm_exp_q.push_back({1'b0, dm_last});
      end
      c0 = cyc;
      for (int i = 0; i < WAIT_BOUND && !got; i++) begin
         @(negedge clk);
         if (dm_ack_o) got = 1'b1;
      end
      lat = int'(cyc - c0);
      if (!got) chk("dm_ack_wait", {63'd0, got}, 64'd1);
      @(posedge clk); #1;
      dm_req_i = 1'b0;
   endtask

   // ---------------- memory responder + grant prediction ----------------
   initial begin : responder
      bit          busy_seen = 1'b0;
      int          wait_left = -1;
      bit          p_if = 1'b0, p_dm = 1'b0, p_we = 1'b0, win_dm;
      logic [31:0] p_if_addr = '0, p_dm_addr = '0, p_wdata = '0;
      logic [3:0]  p_strb = '0;
      mem_ack_i   = 1'b0;
      mem_rdata_i = '0;
      forever begin
         @(negedge clk);
         mem_ack_i   = 1'b0;
         mem_rdata_i = $urandom;
         if (!reset) begin
            busy_seen = 1'b0;
            model_run = 0;
         end else if (mem_req_o) begin
            if (!busy_seen) begin
               busy_seen = 1'b1;
               // Grant was decided from the requests visible one edge ago.
               if (!p_if && !p_dm) begin
                  chk("grant_without_req", {63'd0, mem_req_o}, 64'd0);
               end else begin
                  win_dm = p_dm && !(p_if && model_run >= MAX_DM_RUN);
                  if (win_dm) begin
                     if (p_if) model_run = (model_run < MAX_DM_RUN) ? model_run + 1 : MAX_DM_RUN;
                     grant_log.push_back("D");
                     chk("dm_mem_addr", {32'd0, mem_addr_o}, {32'd0, p_dm_addr});
                     chk("dm_mem_we", {63'd0, mem_we_o}, {63'd0, p_we});
                     chk("dm_mem_strb", {60'd0, mem_strb_o}, {60'd0, p_strb});
                     if (p_we) chk("dm_mem_wdata", {32'd0, mem_wdata_o}, {32'd0, p_wdata});
                  end else begin
                     model_run = 0;
                     grant_log.push_back("I");
                     chk("if_mem_addr", {32'd0, mem_addr_o}, {32'd0, p_if_addr});
                     chk("if_mem_we_strb", {59'd0, mem_we_o, mem_strb_o}, 64'd0);
                  end
               end
               if (is_hang(mem_addr_o)) wait_left = -1;
               else if (fixed_lat >= 0) wait_left = fixed_lat;
               else wait_left = $urandom_range(0, 3);
            end
            if (wait_left == 0) begin
               mem_ack_i   = 1'b1;
               mem_rdata_i = mem_fn(mem_addr_o);
            end
            if (wait_left >= 0) wait_left--;
         end else begin
            busy_seen = 1'b0;
            if (force_spur || $urandom_range(0, 5) == 0) mem_ack_i = 1'b1;
         end
         p_if = if_req_i; p_dm = dm_req_i; p_if_addr = if_addr_i; p_dm_addr = dm_addr_i;
         p_we = dm_we_i; p_wdata = dm_wdata_i; p_strb = dm_strb_i;
      end
   end

   // ---------------- monitor ----------------
   initial begin : monitor
      logic [32:0] e;
      forever begin
         @(negedge clk);
         if (reset) begin
            chk("ack_exclusive", {63'd0, if_ack_o & dm_ack_o}, 64'd0);
            chk("stall_fetch", {63'd0, stall_fetch_o}, {63'd0, if_req_i & ~if_ack_o});
            chk("stall_mem", {63'd0, stall_mem_o}, {63'd0, dm_req_i & ~dm_ack_o});
            if (err_o && !if_ack_o && !dm_ack_o) chk("err_without_ack", {63'd0, err_o}, 64'd0);
            if (if_ack_o) begin
               if (if_exp_q.size() == 0) chk("if_ack_unexpected", {63'd0, if_ack_o}, 64'd0);
               else begin
                  e = if_exp_q.pop_front();
                  chk("if_rdata", {32'd0, if_rdata_o}, {32'd0, e[31:0]});
                  chk("if_err", {63'd0, err_o}, {63'd0, e[32]});
               end
            end
            if (dm_ack_o) begin
               if (dm_exp_q.size() == 0) chk("dm_ack_unexpected", {63'd0, dm_ack_o}, 64'd0);
               else begin
                  e = dm_exp_q.pop_front();
                  chk("dm_rdata", {32'd0, dm_rdata_o}, {32'd0, e[31:0]});
                  chk("dm_err", {63'd0, err_o}, {63'd0, e[32]});
               end
            end
         end
      end
   end

   initial begin : global_guard
      #1ms;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1, "global timeout");
   end

   // ---------------- main sequence ----------------
   initial begin : main_seq
      int  lat_i, lat_d, s;
      byte exp_ord[5];
      logic [31:0] a;
      bit  got;
      exp_ord = '{"D", "D", "D", "I", "D"};
      if_req_i = 0; if_addr_i = 0; dm_req_i = 0; dm_we_i = 0;
      dm_addr_i = 0; dm_wdata_i = 0; dm_strb_i = 0;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_mem_req", {63'd0, mem_req_o}, 64'd0);
      chk("rst_mem_we_strb", {59'd0, mem_we_o, mem_strb_o}, 64'd0);
      chk("rst_mem_addr_wdata", {mem_addr_o, mem_wdata_o}, 64'd0);
      chk("rst_acks_err", {61'd0, if_ack_o, dm_ack_o, err_o}, 64'd0);
      chk("rst_rdata", {if_rdata_o, dm_rdata_o}, 64'd0);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1;

      // Lone fetch, memory answers one cycle after mem_req_o.
      fixed_lat = 1;
      if_issue(32'h100, 0, lat_i);
      chk("fetch_latency", 64'(lat_i), 64'd3);
      @(negedge clk);
      chk("fetch_ack_one_cycle", {63'd0, if_ack_o}, 64'd0);
      chk("fetch_rdata_hold", {32'd0, if_rdata_o}, 64'h2402000A);
      fixed_lat = -1;
      @(posedge clk); #1;

      // Simultaneous requests: data write first, then the fetch.
      s = grant_log.size();
      fork
         dm_issue(32'h40, 1'b1, 32'hDEADBEEF, 4'hF, 0, lat_d);
         if_issue(32'h200, 0, lat_i);
      join
      chk("dm_before_if", {63'd0, lat_d < lat_i}, 64'd1);
      if (grant_log.size() >= s + 2) chk("sim_order", {48'd0, grant_log[s], grant_log[s+1]}, {48'd0, "DI"});
      else chk("sim_grant_count", 64'(grant_log.size() - s), 64'd2);

      // Starvation guard: DM,DM,DM,IF,DM.
      s = grant_log.size();
      fork
         if_issue(32'h300, 0, lat_i);
         begin
            for (int k = 0; k < 5; k++) dm_issue(32'h1000 + 32'(k * 4), (k % 2) == 1, $urandom, 4'h5, 0, lat_d);
         end
      join
      if (grant_log.size() >= s + 5) begin
         for (int k = 0; k < 5; k++) chk("starve_order", 64'(grant_log[s+k]), 64'(exp_ord[k]));
      end else chk("starve_grant_count", 64'(grant_log.size() - s), 64'd6);

      // Watchdog abort on a fetch.
      if_issue(32'hF000_0100, 0, lat_i);
      chk("timeout_latency", 64'(lat_i), 64'(TIMEOUT + 1));
      chk("timeout_rdata_kept", {32'd0, if_rdata_o}, {32'd0, mem_fn(32'h300)});

      // Spurious memory acks with nothing requested.
      force_spur = 1'b1;
      repeat (6) begin
         @(negedge clk);
         chk("spur_mem_req", {63'd0, mem_req_o}, 64'd0);
         chk("spur_acks", {62'd0, if_ack_o, dm_ack_o}, 64'd0);
      end
      force_spur = 1'b0;
      @(posedge clk); #1;

      // Reset in the middle of a data access, fetch pending at release.
      dm_addr_i = 32'hF000_0040; dm_we_i = 1'b1; dm_wdata_i = 32'h1234_5678; dm_strb_i = 4'h3;
      dm_req_i = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = mem_req_o; end
      chk("rst_test_busy", {63'd0, got}, 64'd1);
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("rst_mid_mem_req", {63'd0, mem_req_o}, 64'd0);
      chk("rst_mid_acks_err", {61'd0, if_ack_o, dm_ack_o, err_o}, 64'd0);
      chk("rst_mid_mem_addr", {32'd0, mem_addr_o}, 64'd0);
      chk("rst_mid_rdata", {if_rdata_o, dm_rdata_o}, 64'd0);
      if_last = '0; dm_last = '0;
      dm_req_i = 1'b0;
      @(posedge clk); #1;
      s = grant_log.size();
      if_start(32'h400);
      @(negedge clk);
      chk("rst_hold_acks", {62'd0, if_ack_o, dm_ack_o}, 64'd0);
      @(posedge clk); #1 reset = 1'b1;
      if_wait(cyc, lat_i);
      if (grant_log.size() > s) chk("rst_first_grant", 64'(grant_log[s]), 64'("I"));
      else chk("rst_grant_count", 64'(grant_log.size() - s), 64'd1);

      // Randomized traffic on both ports.
      fork
         begin
            for (int k = 0; k < 60; k++) begin
               a = $urandom;
               a[31:28] = ($urandom_range(0, 39) == 0) ? 4'hF : 4'($urandom_range(0, 14));
               if_issue(a, $urandom_range(0, 3), lat_i);
            end
         end
         begin
            logic [31:0] b;
            for (int k = 0; k < 60; k++) begin
               b = $urandom;
               b[31:28] = ($urandom_range(0, 39) == 0) ? 4'hF : 4'($urandom_range(0, 14));
               dm_issue(b, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                        $urandom_range(0, 3), lat_d);
            end
         end
      join

      repeat (4) @(negedge clk);
      chk("if_q_drained", 64'(if_exp_q.size()), 64'd0);
      chk("dm_q_drained", 64'(dm_exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MAX_DM_RUN, default 3: max consecutive data-side grants while a fetch request waits.
REQ-002 Parameter TIMEOUT, default 255: cycles an outstanding memory access may wait for mem_ack_i before abort.
REQ-003 The module SHALL have one clock, clk, and its reset port SHALL be named reset, asynchronous and active-low.
REQ-004 Ports SHALL be: clk in 1 clock; reset in 1 async active-low reset; if_req_i in 1 fetch request; if_addr_i in 32 fetch address; if_rdata_o out 32 fetch data; if_ack_o out 1 fetch done.
REQ-005 Ports SHALL be: dm_req_i in 1 data request; dm_we_i in 1 write; dm_addr_i in 32; dm_wdata_i in 32; dm_strb_i in 4 byte strobes; dm_rdata_o out 32; dm_ack_o out 1 data done.
REQ-006 Ports SHALL be: mem_req_o out 1; mem_we_o out 1; mem_addr_o out 32; mem_wdata_o out 32; mem_strb_o out 4; mem_rdata_i in 32; mem_ack_i in 1 (single-ported unified memory).
REQ-007 Ports SHALL be: stall_fetch_o out 1; stall_mem_o out 1; err_o out 1 timeout pulse.

Function
REQ-008 FSM states SHALL be IDLE, IF_BUSY, DM_BUSY, RESP; arbitration occurs only in IDLE.
REQ-009 IDLE: dm_req_i only -> DM_BUSY; if_req_i only -> IF_BUSY; both -> DM_BUSY, except IF_BUSY when dm_run == MAX_DM_RUN.
REQ-010 On grant, addr/we/wdata/strb of the winner SHALL be latched; mem_* outputs SHALL be driven from these registers; fetch grants drive mem_we_o=0, mem_strb_o=4'h0.
REQ-011 mem_req_o SHALL be 1 throughout IF_BUSY/DM_BUSY and 0 in IDLE/RESP; first asserted the cycle after the grant.
REQ-012 In a BUSY state, mem_ack_i=1 SHALL latch mem_rdata_i into the owner's rdata register and go to RESP.
REQ-013 In RESP the owner's ack_o SHALL be 1 for exactly one cycle; next state IDLE unconditionally.
REQ-014 Latency: request seen in IDLE at cycle N, mem_ack_i at cycle M>=N+1 -> owner ack_o at M+1; minimum request-to-ack 3 cycles.
REQ-015 Requesters hold req/addr/data stable until their ack_o; the arbiter samples them only in IDLE.
REQ-016 if_rdata_o/dm_rdata_o SHALL hold their last value until the next completion for that side; a data write returns mem_rdata_i unmodified.
REQ-017 dm_run (counter wide enough for MAX_DM_RUN): +1 on a DM grant while if_req_i=1, saturating at MAX_DM_RUN; cleared on any IF grant; unchanged on a DM grant with if_req_i=0.
REQ-018 Watchdog counter SHALL clear on grant and increment each BUSY cycle without mem_ack_i; reaching TIMEOUT -> RESP with owner ack_o=1, err_o=1 same cycle, rdata register unchanged.
REQ-019 mem_ack_i in IDLE or RESP SHALL be ignored.
REQ-020 stall_fetch_o = if_req_i & ~if_ack_o; stall_mem_o = dm_req_i & ~dm_ack_o (combinational).
REQ-021 if_ack_o and dm_ack_o SHALL never be 1 in the same cycle.

Reset
REQ-022 reset=0 SHALL immediately force IDLE, mem_req_o=0, mem_we_o=0, mem_strb_o=0, mem_addr_o=0, mem_wdata_o=0, both ack_o=0, err_o=0, both rdata=0, dm_run=0, watchdog=0.
REQ-023 Reset mid-access SHALL abandon the transaction without any ack_o or err_o pulse; after release, arbitration restarts in IDLE.

Verification
REQ-024 Fetch only: if_addr_i=0x100, memory acks 1 cycle after mem_req_o with 0x2402000A -> mem_addr_o=0x100, if_rdata_o=0x2402000A, if_ack_o one cycle, 3 cycles req-to-ack.
REQ-025 Simultaneous if_req_i/dm_req_i (dm write 0x40, 0xDEADBEEF, strb 0xF) -> DM served first, mem_we_o=1; then fetch served; stall_fetch_o=1 until if_ack_o.
REQ-026 Starvation: dm_req_i continuously high, if_req_i high -> grants DM,DM,DM,IF,DM... (MAX_DM_RUN=3).
REQ-027 Timeout: mem_ack_i held 0 -> after 255 BUSY cycles owner ack_o=1 with err_o=1, rdata unchanged, FSM back to IDLE.
REQ-028 reset=0 asserted mid DM_BUSY -> mem_req_o=0 same cycle, no dm_ack_o; after release, pending if_req_i granted first.
REQ-029 Spurious mem_ack_i in IDLE with no request -> no ack_o, no state change.
